// File: rtl/fir_pkg.sv
// Shared definitions for the N-tap pipelined FIR.
//   acc_width()  : full-precision accumulator width (no overflow for any input/coeff)
//   out_width()  : result width after the fractional shift
//   ROUND_*      : values for the ROUND parameter
//   Default coefficients are Q1.15: 0.125, 0.25, 0.25, 0.125 (h0 in the LSBs).
package fir_pkg;

  localparam int unsigned ROUND_TRUNCATE = 0;
  localparam int unsigned ROUND_HALF_UP  = 1;

  localparam logic signed [15:0] COEFF_Q15_EIGHTH  = 16'sd4096;
  localparam logic signed [15:0] COEFF_Q15_QUARTER = 16'sd8192;

  localparam logic [63:0] DEFAULT_COEFF_INIT = {COEFF_Q15_EIGHTH, COEFF_Q15_QUARTER,
                                                COEFF_Q15_QUARTER, COEFF_Q15_EIGHTH};

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned cw,
                                            input int unsigned n);
    return dw + cw + $clog2(n);
  endfunction

  function automatic int unsigned out_width(input int unsigned dw, input int unsigned cw,
                                            input int unsigned n, input int unsigned frac);
    return acc_width(dw, cw, n) - frac;
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Sample delay line: NUM_TAPS x DATA_WIDTH shift register.
//   clk   : clock
//   reset : synchronous, active-low; clears every tap
//   en    : shift in din this edge (otherwise all taps hold)
//   din   : new sample, becomes tap 0
//   taps  : all taps packed, tap 0 in the LSBs
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int unsigned NUM_TAPS   = 4,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic [DATA_WIDTH-1:0]          din,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] taps
);

  logic [NUM_TAPS*DATA_WIDTH-1:0] taps_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      taps_q <= '0;
    end else if (en) begin
      taps_q <= {taps_q[(NUM_TAPS-1)*DATA_WIDTH-1:0], din};
    end
  end

  assign taps = taps_q;

endmodule

// File: rtl/fir_ntap_pipelined.sv
// Parametrised N-tap direct-form FIR with a two-stage pipelined datapath.
// Accepting edge loads the delay line; the next edge registers the products; the edge after
// that registers the shifted full-precision sum, so results appear 2 edges after acceptance.
// Optional feature macro: FIR_COEFF_LOAD_EN (runtime-writable coefficients and i_coeff_* ports).
//   clk          : clock
//   reset        : synchronous, active-low
//   i_valid      : i_data is a new sample
//   i_data       : signed sample
//   i_coeff_we   : coefficient write strobe        (FIR_COEFF_LOAD_EN only)
//   i_coeff_addr : tap index to write              (FIR_COEFF_LOAD_EN only)
//   i_coeff_data : signed coefficient              (FIR_COEFF_LOAD_EN only)
//   o_data_sum   : signed result, holds between results
//   o_data_valid : one-cycle pulse per result
module fir_ntap_pipelined
  import fir_pkg::*;
#(
  parameter int unsigned                      NUM_TAPS             = 4,
  parameter int unsigned                      DATA_WIDTH           = 16,
  parameter int unsigned                      COEFF_WIDTH          = 16,
  parameter int unsigned                      COEFF_FRACTION_WIDTH = 15,
  parameter int unsigned                      ROUND                = ROUND_TRUNCATE,
  parameter logic [NUM_TAPS*COEFF_WIDTH-1:0]  COEFF_INIT           = DEFAULT_COEFF_INIT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_valid,
  input  logic signed [DATA_WIDTH-1:0]  i_data,
`ifdef FIR_COEFF_LOAD_EN
  input  logic                          i_coeff_we,
  input  logic [$clog2(NUM_TAPS)-1:0]   i_coeff_addr,
  input  logic signed [COEFF_WIDTH-1:0] i_coeff_data,
`endif
  output logic signed [out_width(DATA_WIDTH, COEFF_WIDTH, NUM_TAPS,
                                 COEFF_FRACTION_WIDTH)-1:0] o_data_sum,
  output logic                          o_data_valid
);

  localparam int unsigned ProdWidth = DATA_WIDTH + COEFF_WIDTH;
  localparam int unsigned AccWidth  = acc_width(DATA_WIDTH, COEFF_WIDTH, NUM_TAPS);
  localparam int unsigned OutWidth  = out_width(DATA_WIDTH, COEFF_WIDTH, NUM_TAPS,
                                                COEFF_FRACTION_WIDTH);
  // Half an output LSB, added once to the whole sum before the shift (round-half-up).
  localparam logic signed [AccWidth-1:0] RoundBias =
      (ROUND != 0 && COEFF_FRACTION_WIDTH > 0) ? AccWidth'(1) << (COEFF_FRACTION_WIDTH - 1)
                                                : '0;

  logic [NUM_TAPS*DATA_WIDTH-1:0] taps;
  logic signed [DATA_WIDTH-1:0]   x     [NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0]  coeff [NUM_TAPS];
  logic signed [ProdWidth-1:0]    prod_q[NUM_TAPS];
  logic                           valid0_q, valid1_q, valid_out_q;
  logic signed [AccWidth-1:0]     acc;
  logic signed [OutWidth-1:0]     sum_d, sum_q;

  fir_delay_line #(
    .NUM_TAPS  (NUM_TAPS),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_delay_line (
    .clk  (clk),
    .reset(reset),
    .en   (i_valid),
    .din  (i_data),
    .taps (taps)
  );

  always_comb begin
    for (int unsigned k = 0; k < NUM_TAPS; k++) begin
      x[k] = taps[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef FIR_COEFF_LOAD_EN
  localparam int unsigned AddrWidth = $clog2(NUM_TAPS);

  logic signed [COEFF_WIDTH-1:0] coeff_q [NUM_TAPS];

  // Addresses with no matching tap simply match nothing and are dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        coeff_q[k] <= COEFF_INIT[k*COEFF_WIDTH +: COEFF_WIDTH];
      end
    end else if (i_coeff_we) begin
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        if (i_coeff_addr == AddrWidth'(k)) coeff_q[k] <= i_coeff_data;
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_TAPS; k++) coeff[k] = coeff_q[k];
  end
`else
  always_comb begin
    for (int unsigned k = 0; k < NUM_TAPS; k++) begin
      coeff[k] = COEFF_INIT[k*COEFF_WIDTH +: COEFF_WIDTH];
    end
  end
`endif

  // Stage 1: products of the freshly loaded delay line.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      for (int unsigned k = 0; k < NUM_TAPS; k++) prod_q[k] <= '0;
    end else begin
      valid0_q <= i_valid;
      valid1_q <= valid0_q;
      if (valid0_q) begin
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
          prod_q[k] <= ProdWidth'(x[k]) * ProdWidth'(coeff[k]);
        end
      end
    end
  end

  always_comb begin
    acc = '0;
    for (int unsigned k = 0; k < NUM_TAPS; k++) acc = acc + AccWidth'(prod_q[k]);
    sum_d = OutWidth'((acc + RoundBias) >>> COEFF_FRACTION_WIDTH);
  end

  // Stage 2: registered result; holds its value while no result is due.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_q       <= '0;
      valid_out_q <= 1'b0;
    end else begin
      valid_out_q <= valid1_q;
      if (valid1_q) sum_q <= sum_d;
    end
  end

  assign o_data_sum   = sum_q;
  assign o_data_valid = valid_out_q;

endmodule

// File: tb/tb_fir_ntap_pipelined.sv
// Bench for fir_ntap_pipelined: directed vector table, full-scale and coefficient-load
// sequences, then randomized streaming against a sample-history reference model.
// Three instances share the inputs: truncating, rounding, and all-coefficients -32768.
module tb_fir_ntap_pipelined;

  localparam int NT = 4;
  localparam int DW = 16;
  localparam int OW = 19;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 i_valid;
  logic signed [DW-1:0] i_data;
  logic signed [OW-1:0] sum_t, sum_r, sum_f;
  logic                 valid_t, valid_r, valid_f;
`ifdef FIR_COEFF_LOAD_EN
  logic                 i_coeff_we;
  logic [1:0]           i_coeff_addr;
  logic signed [15:0]   i_coeff_data;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_ntap_pipelined #(.ROUND(0)) u_trunc (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data),
`ifdef FIR_COEFF_LOAD_EN
    .i_coeff_we(i_coeff_we), .i_coeff_addr(i_coeff_addr), .i_coeff_data(i_coeff_data),
`endif
    .o_data_sum(sum_t), .o_data_valid(valid_t)
  );

  fir_ntap_pipelined #(.ROUND(1)) u_round (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data),
`ifdef FIR_COEFF_LOAD_EN
    .i_coeff_we(i_coeff_we), .i_coeff_addr(i_coeff_addr), .i_coeff_data(i_coeff_data),
`endif
    .o_data_sum(sum_r), .o_data_valid(valid_r)
  );

  fir_ntap_pipelined #(.ROUND(0), .COEFF_INIT({4{16'h8000}})) u_fs (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data),
`ifdef FIR_COEFF_LOAD_EN
    .i_coeff_we(1'b0), .i_coeff_addr(2'd0), .i_coeff_data(16'sd0),
`endif
    .o_data_sum(sum_f), .o_data_valid(valid_f)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Directed vectors: inputs for one edge, expected outputs right after that edge.
  typedef struct {
    bit rst_n;
    bit vld;
    int data;
    bit ev;
    int et;
    int er;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit rst_n, input bit vld, input int data,
                              input bit ev, input int et, input int er);
    vec_t v;
    v.rst_n = rst_n; v.vld = vld; v.data = data; v.ev = ev; v.et = et; v.er = er;
    vecs.push_back(v);
  endfunction

  // Reference model: accepted-sample history and results due at a given edge.
  typedef struct {
    int     due;
    longint t;
    longint r;
    longint f;
  } pend_t;

  pend_t  pend[$];
  longint hist[NT];
  longint h_def[NT];
  longint h_fs[NT];
  longint held_t, held_r, held_f;
  int     cyc = 0;

  function automatic void model_reset();
    pend.delete();
    for (int k = 0; k < NT; k++) begin
      hist[k] = 0;
      h_fs[k] = -32768;
    end
    h_def[0] = 4096; h_def[1] = 8192; h_def[2] = 8192; h_def[3] = 4096;
    held_t = 0; held_r = 0; held_f = 0;
  endfunction

  function automatic void model_edge(input bit r, input bit v, input longint d,
                                     input bit we, input int addr, input longint cd);
    longint sd, sf;
    pend_t  p;
    if (!r) begin
      model_reset();
    end else begin
      if (we) h_def[addr] = cd;
      if (v) begin
        for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = d;
        sd = 0; sf = 0;
        for (int k = 0; k < NT; k++) begin
          sd += hist[k] * h_def[k];
          sf += hist[k] * h_fs[k];
        end
        p.due = cyc + 2;
        p.t = sd >>> 15;
        p.r = (sd + 16384) >>> 15;
        p.f = sf >>> 15;
        pend.push_back(p);
      end
    end
  endfunction

  task automatic model_check();
    bit ev;
    ev = (pend.size() > 0) && (pend[0].due == cyc);
    if (ev) begin
      held_t = pend[0].t; held_r = pend[0].r; held_f = pend[0].f;
      void'(pend.pop_front());
    end
    check("rand_valid_t", longint'(valid_t), longint'(ev));
    check("rand_valid_r", longint'(valid_r), longint'(ev));
    check("rand_valid_f", longint'(valid_f), longint'(ev));
    check("rand_sum_t", longint'(sum_t), held_t);
    check("rand_sum_r", longint'(sum_r), held_r);
    check("rand_sum_f", longint'(sum_f), held_f);
  endtask

  task automatic rand_step(input bit force_rst);
    bit r, v, we;
    int d, addr, cd;
    r = force_rst ? 1'b0 : ($urandom_range(0, 63) != 0);
    v = ($urandom_range(0, 3) != 0);
    case ($urandom_range(0, 9))
      0:       d = -32768;
      1:       d = 32767;
      default: d = int'($urandom_range(0, 65535)) - 32768;
    endcase
    we = 1'b0; addr = 0; cd = 0;
`ifdef FIR_COEFF_LOAD_EN
    we = ($urandom_range(0, 7) == 0);
    addr = int'($urandom_range(0, 3));
    cd = int'($urandom_range(0, 65535)) - 32768;
    i_coeff_we = we; i_coeff_addr = 2'(addr); i_coeff_data = 16'(cd);
`endif
    reset = r; i_valid = v; i_data = 16'(d);
    @(posedge clk);
    cyc++;
    model_edge(r, v, longint'(d), we, addr, longint'(cd));
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int step_in[5];
    int step_t[5];
    int step_r[5];
    int pt, pr;

    step_in = '{100, 200, 300, 400, 0};
    step_t  = '{12, 50, 112, 187, 200};
    step_r  = '{13, 50, 113, 188, 200};

    reset = 1'b0; i_valid = 1'b0; i_data = '0;
`ifdef FIR_COEFF_LOAD_EN
    i_coeff_we = 1'b0; i_coeff_addr = '0; i_coeff_data = '0;
`endif

    // Reset state, then impulse of 32767.
    add(0, 0, 0, 0, 0, 0);
    add(1, 1, 32767, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0);
    add(1, 1, 0, 1, 4095, 4096);
    add(1, 1, 0, 1, 8191, 8192);
    add(1, 1, 0, 1, 8191, 8192);
    add(1, 0, 0, 1, 4095, 4096);
    add(1, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0);
    // Back-to-back step sequence.
    add(1, 1, 100, 0, 0, 0);
    add(1, 1, 200, 0, 0, 0);
    add(1, 1, 300, 1, 12, 13);
    add(1, 1, 400, 1, 50, 50);
    add(1, 1, 0, 1, 112, 113);
    add(1, 0, 0, 1, 187, 188);
    add(1, 0, 0, 1, 200, 200);
    add(1, 0, 0, 0, 200, 200);
    // Same sequence with 3 idle cycles between samples.
    add(0, 0, 0, 0, 0, 0);
    pt = 0; pr = 0;
    for (int j = 0; j < 5; j++) begin
      add(1, 1, step_in[j], 0, pt, pr);
      add(1, 0, 0, 0, pt, pr);
      add(1, 0, 0, 1, step_t[j], step_r[j]);
      add(1, 0, 0, 0, step_t[j], step_r[j]);
      pt = step_t[j]; pr = step_r[j];
    end
    add(1, 0, 0, 0, 200, 200);
    // Reset between samples 2 and 3; the sample offered during reset is dropped.
    add(1, 1, 100, 0, 200, 200);
    add(1, 1, 200, 0, 200, 200);
    add(0, 1, 999, 0, 0, 0);
    add(1, 1, 300, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 37, 38);
    add(1, 0, 0, 0, 37, 38);
    // Negative input: floor vs round-half-up.
    add(0, 0, 0, 0, 0, 0);
    add(1, 1, -100, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, -13, -12);
    add(1, 0, 0, 0, -13, -12);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst_n; i_valid = vecs[i].vld; i_data = 16'(vecs[i].data);
      tick();
      check($sformatf("vec%0d_valid_t", i), longint'(valid_t), longint'(vecs[i].ev));
      check($sformatf("vec%0d_valid_r", i), longint'(valid_r), longint'(vecs[i].ev));
      check($sformatf("vec%0d_sum_t", i), longint'(sum_t), longint'(vecs[i].et));
      check($sformatf("vec%0d_sum_r", i), longint'(sum_r), longint'(vecs[i].er));
    end

    // Full scale: -32768 on every tap against -32768 coefficients.
    reset = 1'b0; i_valid = 1'b0; tick();
    reset = 1'b1;
    for (int j = 0; j < 4; j++) begin
      i_valid = 1'b1; i_data = 16'sh8000; tick();
    end
    i_valid = 1'b0; tick();
    check("fs_three_taps_valid", longint'(valid_f), 1);
    check("fs_three_taps_sum", longint'(sum_f), 98304);
    tick();
    check("fs_four_taps_valid", longint'(valid_f), 1);
    check("fs_four_taps_sum", longint'(sum_f), 131072);
    check("fs_default_coeff_sum", longint'(sum_t), -24576);

`ifdef FIR_COEFF_LOAD_EN
    // h1..h3 cleared, then h0 = 32767 written on the same edge as sample 1000.
    reset = 1'b0; tick();
    reset = 1'b1;
    i_coeff_we = 1'b1; i_coeff_data = 16'sd0;
    for (int a = 1; a < 4; a++) begin
      i_coeff_addr = 2'(a); tick();
    end
    i_coeff_addr = 2'd0; i_coeff_data = 16'sd32767; i_valid = 1'b1; i_data = 16'sd1000;
    tick();
    i_coeff_we = 1'b0; i_valid = 1'b0;
    tick();
    tick();
    check("load_valid", longint'(valid_t), 1);
    check("load_sum_t", longint'(sum_t), 999);
    check("load_sum_r", longint'(sum_r), 1000);
`endif

    model_reset();
    rand_step(1'b1);
    for (int n = 0; n < 3000; n++) rand_step(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
